i_mem_loader: RTL

I_MEM_LOADER -- requirements
Module: i_mem_loader

---
 rtl/i_mem_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/i_mem_loader.sv
// Serial program loader: shifts 16-bit words in MSB-first, writes each to instruction memory, then pulses cpu_start.
// mem_we rises the cycle after a word's 16th valid bit; no backpressure on sdi, so a bit that arrives during WRITE is dropped and flagged in overrun.
module i_mem_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [7:0]  base_addr,
    input  logic [7:0]  load_len,
    input  logic        sdi,
    input  logic        sdi_valid,
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_dataout,
    output logic        cpu_start,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, SHIFT, WRITE, START, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [15:0] dout_q, dout_d;
    logic        ovr_q, ovr_d;
    logic        load_acc;
    logic        last_bit;

    assign load_acc = enable && load && (state_q == IDLE || state_q == DONE);
    assign last_bit = sdi_valid && (bit_cnt_q == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                IDLE, DONE: if (load) state_d = (load_len == 8'd0) ? START : SHIFT;
                SHIFT:      if (last_bit) state_d = WRITE;
                WRITE:      state_d = (word_cnt_q + 8'd1 == len_q) ? START : SHIFT;
                START:      state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= 8'd0;
            len_q      <= 8'd0;
            word_cnt_q <= 8'd0;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 16'd0;
            dout_q     <= 16'd0;
            ovr_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            dout_q     <= dout_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        dout_d     = dout_q;
        ovr_d      = ovr_q;
        if (load_acc) begin
            addr_d     = base_addr;
            len_d      = load_len;
            word_cnt_d = 8'd0;
            bit_cnt_d  = 4'd0;
            shreg_d    = 16'd0;
            ovr_d      = 1'b0;
        end else if (enable && state_q == SHIFT && sdi_valid) begin
            shreg_d   = {shreg_q[14:0], sdi};
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Latch the finished word separately so mem_dataout keeps the last written word while the next one shifts in.
            if (last_bit) dout_d = {shreg_q[14:0], sdi};
        end else if (enable && state_q == WRITE) begin
            addr_d     = addr_q + 8'd1;
            word_cnt_d = word_cnt_q + 8'd1;
            if (sdi_valid) ovr_d = 1'b1;
        end
    end

    always_comb begin
        mem_we    = enable && (state_q == WRITE);
        cpu_start = enable && (state_q == START);
        busy      = (state_q == SHIFT) || (state_q == WRITE) || (state_q == START);
        done      = (state_q == DONE);
    end

    assign mem_addr    = addr_q;
    assign mem_dataout = dout_q;
    assign overrun     = ovr_q;

endmodule
